// File: rtl/stack_tower_pkg.sv
// -----------------------------------------------------------------------------
// stack_tower_pkg
//   Shared game definitions for the stacking game: screen geometry, tower
//   geometry defaults, colour codes, catch FSM encodings and the signed
//   coordinate type used by the hit comparators.
// -----------------------------------------------------------------------------
package stack_tower_pkg;

  // Screen geometry (px)
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Tower geometry defaults (px)
  localparam int BASE_Y   = 400;
  localparam int BLOCK_H  = 20;
  localparam int X_INIT   = 300;
  localparam int X_MIN    = 0;
  localparam int X_MAX    = 490;

  // Catch window defaults (px)
  localparam int X_TOL    = 15;
  localparam int Y_TOL_UP = 5;
  localparam int Y_TOL_DN = 30;

  // Block colour codes
  localparam int COLOR_W = 2;
  localparam logic [1:0] COLOR_RED    = 2'd0;
  localparam logic [1:0] COLOR_GREEN  = 2'd1;
  localparam logic [1:0] COLOR_BLUE   = 2'd2;
  localparam logic [1:0] COLOR_YELLOW = 2'd3;

  // Catch FSM encodings
  localparam logic [1:0] ST_ARMED   = 2'd0;
  localparam logic [1:0] ST_LATCHED = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  // 12-bit signed screen coordinate: wide enough that x-X_TOL or
  // pos_y-Y_TOL_UP never wraps around below zero.
  typedef logic signed [11:0] coord_t;

  // Widen an unsigned 10-bit pixel coordinate into the signed compare domain.
  function automatic coord_t to_coord(input logic [9:0] px);
    to_coord = coord_t'({2'b00, px});
  endfunction

endpackage

// File: rtl/stack_tower_tick_div.sv
// -----------------------------------------------------------------------------
// tick_div
//   Free-running W-bit divider. Counts while en is high, holds otherwise, and
//   emits a one-cycle tick on the clock edge where the count wraps to zero.
//   Shared with the spawner.
// Ports
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset (count -> 0)
//   clr    in  synchronous clear (count -> 0)
//   en     in  count enable
//   tick   out high in the cycle whose closing edge wraps the count to 0
// -----------------------------------------------------------------------------
module tick_div #(
  parameter int W = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [W-1:0] cnt_r;

  // The wrap happens on the edge that follows an all-ones count, so the tick
  // is qualified with en: a held divider never wraps.
  assign tick = en && (cnt_r == {W{1'b1}}) && !clr;

  // Divider count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/stack_tower.sv
// -----------------------------------------------------------------------------
// stack_tower
//   Player-controlled catch tower. Moves the base column left/right on a
//   divided tick, detects the live falling block landing on the tower top,
//   latches each catch exactly once, pushes the block colour into a colour
//   stack and reports the height.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           synchronous restart (same effect as reset)
//   pause           freezes movement, divider and catch detection
//   left, right     level move requests
//   fall_valid      falling block is live
//   fall_x, fall_y  falling block top-left (px)
//   fall_color      falling block colour
//   pos_x, pos_y    tower x and top-surface y (px)
//   height          caught block count
//   colors          colour stack, newest block in [COLOR_W-1:0]
//   collision       one-cycle pulse per catch
//   full            height == MAX_BLOCKS
// All outputs are registered.
// -----------------------------------------------------------------------------
module stack_tower
  import stack_tower_pkg::*;
#(
  parameter int MAX_BLOCKS = 16,
  parameter int COLOR_W    = stack_tower_pkg::COLOR_W,
  parameter int BASE_Y     = stack_tower_pkg::BASE_Y,
  parameter int BLOCK_H    = stack_tower_pkg::BLOCK_H,
  parameter int X_INIT     = stack_tower_pkg::X_INIT,
  parameter int X_MIN      = stack_tower_pkg::X_MIN,
  parameter int X_MAX      = stack_tower_pkg::X_MAX,
  parameter int X_TOL      = stack_tower_pkg::X_TOL,
  parameter int Y_TOL_UP   = stack_tower_pkg::Y_TOL_UP,
  parameter int Y_TOL_DN   = stack_tower_pkg::Y_TOL_DN,
  parameter int DIV_W      = 18
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic                                 pause,
  input  logic                                 left,
  input  logic                                 right,
  input  logic                                 fall_valid,
  input  logic [9:0]                           fall_x,
  input  logic [9:0]                           fall_y,
  input  logic [COLOR_W-1:0]                   fall_color,
  output logic [9:0]                           pos_x,
  output logic [9:0]                           pos_y,
  output logic [$clog2(MAX_BLOCKS+1)-1:0]      height,
  output logic [MAX_BLOCKS*COLOR_W-1:0]        colors,
  output logic                                 collision,
  output logic                                 full
);

  localparam int HW    = $clog2(MAX_BLOCKS+1);
  localparam int CS_W  = MAX_BLOCKS*COLOR_W;

  localparam logic [9:0]    X_INIT_C   = 10'(X_INIT);
  localparam logic [9:0]    X_MIN_C    = 10'(X_MIN);
  localparam logic [9:0]    X_MAX_C    = 10'(X_MAX);
  localparam logic [HW-1:0] MAX_H_C    = HW'(MAX_BLOCKS);
  localparam logic [HW-1:0] ONE_H_C    = {{(HW-1){1'b0}}, 1'b1};
  localparam coord_t        X_TOL_C    = coord_t'(X_TOL);
  localparam coord_t        Y_TOL_UP_C = coord_t'(Y_TOL_UP);
  localparam coord_t        Y_TOL_DN_C = coord_t'(Y_TOL_DN);

  // Top-surface y for a given stack height.
  function automatic logic [9:0] top_y(input logic [HW-1:0] h);
    logic [15:0] drop;
    drop  = 16'(h) * 16'(BLOCK_H);
    top_y = 10'(16'(BASE_Y) - drop);
  endfunction

  // Registered state
  logic [1:0]       state_r;
  logic [9:0]       x_r;
  logic [9:0]       pos_y_r;
  logic [HW-1:0]    height_r;
  logic [CS_W-1:0]  colors_r;
  logic             collision_r;
  logic             full_r;

  // Next-state values
  logic [1:0]       state_s;
  logic [9:0]       x_s;
  logic [HW-1:0]    height_s;
  logic [CS_W-1:0]  colors_s;
  logic             collision_s;

  // Hit compare
  logic             tick_s;
  logic             x_ok_s;
  logic             y_ok_s;
  logic             room_s;
  logic             hit_s;
  coord_t           tx_s;
  coord_t           ty_s;
  coord_t           fx_s;
  coord_t           fy_s;

  tick_div #(.W(DIV_W)) u_tick_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .en    (!pause),
    .tick  (tick_s)
  );

  assign tx_s = to_coord(x_r);
  assign ty_s = to_coord(pos_y_r);
  assign fx_s = to_coord(fall_x);
  assign fy_s = to_coord(fall_y);

  // Strict inequalities: a block exactly X_TOL away, or exactly Y_TOL_UP
  // above the top surface, is a miss.
  assign x_ok_s = (fx_s > (tx_s - X_TOL_C)) && (fx_s < (tx_s + X_TOL_C));
  assign y_ok_s = (fy_s > (ty_s - Y_TOL_UP_C)) && (fy_s < (ty_s + Y_TOL_DN_C));
  // Guards the stack against overflow even if the FSM were ever corrupted.
  assign room_s = (height_r < MAX_H_C);
  assign hit_s  = fall_valid && x_ok_s && y_ok_s && room_s && !pause;

  // Catch FSM, height counter and colour stack next-state
  always_comb begin
    state_s     = state_r;
    height_s    = height_r;
    colors_s    = colors_r;
    collision_s = 1'b0;
    if (pause) begin
      state_s = state_r;
    end else begin
      case (state_r)
        ST_ARMED: begin
          if (hit_s) begin
            collision_s = 1'b1;
            height_s    = height_r + ONE_H_C;
            colors_s    = {colors_r[CS_W-COLOR_W-1:0], fall_color};
            if ((height_r + ONE_H_C) == MAX_H_C) begin
              state_s = ST_FULL;
            end else begin
              state_s = ST_LATCHED;
            end
          end else begin
            state_s = ST_ARMED;
          end
        end
        ST_LATCHED: begin
          // The block stays latched until the spawner drops fall_valid,
          // so a block lingering in the window never scores twice.
          if (height_r == MAX_H_C) begin
            state_s = ST_FULL;
          end else if (!fall_valid) begin
            state_s = ST_ARMED;
          end else begin
            state_s = ST_LATCHED;
          end
        end
        ST_FULL: begin
          state_s = ST_FULL;
        end
        default: begin
          state_s = ST_ARMED;
        end
      endcase
    end
  end

  // Horizontal movement with clamping; both or neither buttons hold.
  always_comb begin
    x_s = x_r;
    if (tick_s && !pause && left && !right) begin
      if (x_r > X_MIN_C) begin
        x_s = x_r - 10'd1;
      end else begin
        x_s = X_MIN_C;
      end
    end else if (tick_s && !pause && right && !left) begin
      if (x_r < X_MAX_C) begin
        x_s = x_r + 10'd1;
      end else begin
        x_s = X_MAX_C;
      end
    end else begin
      x_s = x_r;
    end
  end

  // State and output registers; clear has the same effect as reset and
  // overrides a simultaneous hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_ARMED;
      x_r         <= X_INIT_C;
      pos_y_r     <= top_y({HW{1'b0}});
      height_r    <= {HW{1'b0}};
      colors_r    <= {CS_W{1'b0}};
      collision_r <= 1'b0;
      full_r      <= 1'b0;
    end else if (clear) begin
      state_r     <= ST_ARMED;
      x_r         <= X_INIT_C;
      pos_y_r     <= top_y({HW{1'b0}});
      height_r    <= {HW{1'b0}};
      colors_r    <= {CS_W{1'b0}};
      collision_r <= 1'b0;
      full_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      x_r         <= x_s;
      pos_y_r     <= top_y(height_s);
      height_r    <= height_s;
      colors_r    <= colors_s;
      collision_r <= collision_s;
      full_r      <= (height_s == MAX_H_C);
    end
  end

  assign pos_x     = x_r;
  assign pos_y     = pos_y_r;
  assign height    = height_r;
  assign colors    = colors_r;
  assign collision = collision_r;
  assign full      = full_r;

endmodule

// File: tb/tb_stack_tower.sv
// -----------------------------------------------------------------------------
// tb_stack_tower
//   Directed scoreboard bench for stack_tower (MAX_BLOCKS=4, DIV_W=2).
//   Each expected catch is queued when its stimulus is issued; a monitor pops
//   and compares on every collision pulse.
// -----------------------------------------------------------------------------
module tb_stack_tower;

  localparam int MAXB = 4;
  localparam int CW   = 2;
  localparam int HW   = $clog2(MAXB+1);

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             pause;
  logic             left;
  logic             right;
  logic             fall_valid;
  logic [9:0]       fall_x;
  logic [9:0]       fall_y;
  logic [CW-1:0]    fall_color;
  logic [9:0]       pos_x;
  logic [9:0]       pos_y;
  logic [HW-1:0]    height;
  logic [MAXB*CW-1:0] colors;
  logic             collision;
  logic             full;

  typedef struct {
    logic [HW-1:0]      h;
    logic [MAXB*CW-1:0] c;
    logic [9:0]         y;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  stack_tower #(.MAX_BLOCKS(MAXB), .DIV_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .pause      (pause),
    .left       (left),
    .right      (right),
    .fall_valid (fall_valid),
    .fall_x     (fall_x),
    .fall_y     (fall_y),
    .fall_color (fall_color),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .height     (height),
    .colors     (colors),
    .collision  (collision),
    .full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every collision pulse must match the next queued catch.
  always @(negedge clk) begin
    if (rst_n && collision) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_collision: got pulse at height %0d, expected none", height);
      end else begin
        mon_e = exp_q.pop_front();
        check("catch_height", 32'(height), 32'(mon_e.h));
        check("catch_colors", 32'(colors), 32'(mon_e.c));
        check("catch_pos_y",  32'(pos_y),  32'(mon_e.y));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic expect_catch(input logic [HW-1:0] h, input logic [MAXB*CW-1:0] c,
                              input logic [9:0] y);
    exp_t e;
    e.h = h; e.c = c; e.y = y;
    exp_q.push_back(e);
  endtask

  // Present a block for 'cycles' clocks, then a 2-cycle fall_valid gap.
  task automatic drive_block(input logic [9:0] x, input logic [9:0] y,
                             input logic [CW-1:0] c, input int cycles);
    fall_x = x; fall_y = y; fall_color = c; fall_valid = 1'b1;
    step(cycles);
    fall_valid = 1'b0;
    step(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; pause = 1'b0; left = 1'b0; right = 1'b0;
    fall_valid = 1'b0; fall_x = 10'd0; fall_y = 10'd0; fall_color = 2'b00;
    step(3);
    rst_n = 1'b1;
    check("rst_x",   32'(pos_x),     32'd300);
    check("rst_y",   32'(pos_y),     32'd400);
    check("rst_h",   32'(height),    32'd0);
    check("rst_col", 32'(colors),    32'd0);
    check("rst_pul", 32'(collision), 32'd0);
    check("rst_full",32'(full),      32'd0);

    // Single catch held 10 cycles: exactly one pulse
    expect_catch(3'd1, 8'h02, 10'd380);
    drive_block(10'd305, 10'd398, 2'b10, 10);
    check("single_pending", 32'(exp_q.size()), 32'd0);
    check("single_h",       32'(height),       32'd1);
    check("single_y",       32'(pos_y),        32'd380);

    // X edge: |dx|=15 misses, 14 hits
    do_clear();
    drive_block(10'd315, 10'd398, 2'b01, 4);
    check("xedge_miss_h", 32'(height), 32'd0);
    expect_catch(3'd1, 8'h01, 10'd380);
    drive_block(10'd314, 10'd398, 2'b01, 4);
    check("xedge_pending", 32'(exp_q.size()), 32'd0);

    // Y edge: 395 vs top 400 misses, 396 hits
    do_clear();
    drive_block(10'd300, 10'd395, 2'b11, 4);
    check("yedge_miss_h", 32'(height), 32'd0);
    expect_catch(3'd1, 8'h03, 10'd380);
    drive_block(10'd300, 10'd396, 2'b11, 4);
    check("yedge_pending", 32'(exp_q.size()), 32'd0);

    // Movement: one tick per 4 clocks, divider phase aligned by clear
    do_clear();
    right = 1'b1;
    step(40);
    check("move_right", 32'(pos_x), 32'd310);
    step(760);
    check("clamp_max", 32'(pos_x), 32'd490);
    left = 1'b1;
    step(20);
    check("both_hold", 32'(pos_x), 32'd490);
    right = 1'b0;
    step(8);
    check("move_left", 32'(pos_x), 32'd488);
    left = 1'b0;
    do_clear();
    left = 1'b1;
    step(1300);
    check("clamp_min", 32'(pos_x), 32'd0);
    left = 1'b0;

    // Full: 5 blocks, only 4 caught
    do_clear();
    expect_catch(3'd1, 8'h01, 10'd380);
    drive_block(10'd300, 10'd398, 2'b01, 3);
    expect_catch(3'd2, 8'h06, 10'd360);
    drive_block(10'd300, 10'd378, 2'b10, 3);
    expect_catch(3'd3, 8'h1B, 10'd340);
    drive_block(10'd300, 10'd358, 2'b11, 3);
    expect_catch(3'd4, 8'h6C, 10'd320);
    drive_block(10'd300, 10'd338, 2'b00, 3);
    drive_block(10'd300, 10'd318, 2'b01, 3);
    check("full_pending", 32'(exp_q.size()), 32'd0);
    check("full_flag",    32'(full),         32'd1);
    check("full_h",       32'(height),       32'd4);
    check("full_col",     32'(colors),       32'h6C);
    check("full_y",       32'(pos_y),        32'd320);

    // Asynchronous reset mid-run, observed between clock edges
    right = 1'b1;
    step(8);
    right = 1'b0;
    check("pre_rst_x", 32'(pos_x), 32'd302);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_x",    32'(pos_x),     32'd300);
    check("async_h",    32'(height),    32'd0);
    check("async_col",  32'(colors),    32'd0);
    check("async_y",    32'(pos_y),     32'd400);
    check("async_pul",  32'(collision), 32'd0);
    check("async_full", 32'(full),      32'd0);
    step(1);
    rst_n = 1'b1;

    // Pause during a valid hit: no pulse, x frozen, hit not queued
    pause = 1'b1; right = 1'b1;
    fall_x = 10'd305; fall_y = 10'd398; fall_color = 2'b10; fall_valid = 1'b1;
    step(12);
    check("pause_x", 32'(pos_x),  32'd300);
    check("pause_h", 32'(height), 32'd0);
    fall_valid = 1'b0;
    step(1);
    pause = 1'b0; right = 1'b0;
    step(3);
    check("unpause_h", 32'(height), 32'd0);

    // Clear together with a hit: clear wins
    fall_valid = 1'b1; clear = 1'b1;
    step(1);
    fall_valid = 1'b0; clear = 1'b0;
    step(2);
    check("clrhit_h", 32'(height), 32'd0);

    // Still armed afterwards
    expect_catch(3'd1, 8'h02, 10'd380);
    drive_block(10'd305, 10'd398, 2'b10, 3);
    check("final_pending", 32'(exp_q.size()), 32'd0);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
